// File: rtl/monitor_3lanpc.sv
// Gate-feedback monitor for one 3L-ANPC leg: level reconstruction, transition timing, fault latching.
module monitor_3lanpc #(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned FILT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              s_1,
  input  logic              s_2,
  input  logic              s_3,
  input  logic              s_4,
  input  logic              s_5,
  input  logic              s_6,
  input  logic [FILT_W-1:0] t_filt,
  input  logic [7:0]        t_dt_max,
  input  logic              fault_clr,
  output logic [1:0]        v_lev_meas,
  output logic              lev_valid,
  output logic [7:0]        dt_last,
  output logic              dt_strobe,
  output logic              fault_short,
  output logic              fault_dt,
  output logic              fault
);

  localparam logic [1:0]        LEV_N    = 2'd0;
  localparam logic [1:0]        LEV_O    = 2'd1;
  localparam logic [1:0]        LEV_P    = 2'd2;
  localparam logic [1:0]        LEV_NONE = 2'd3;
  localparam logic [FILT_W-1:0] STAB_ONE = FILT_W'(1);
  localparam logic [FILT_W-1:0] STAB_MAX = '1;

  typedef enum logic [1:0] {INIT, STABLE, TRANS, FAULT} state_t;

  state_t            state_q, state_d;
  logic [5:0]        sync_q [SYNC_STG];
  logic [5:0]        ss;
  logic [1:0]        cls, cls_q;
  logic              sc, acc;
  logic [FILT_W-1:0] stab_cnt;
  logic [7:0]        dt_cnt, dt_cnt_d, dt_last_d;
  logic [1:0]        lev_d;
  logic              valid_d, strobe_d, fs_d, fd_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {s_1, s_2, s_3, s_4, s_5, s_6};
      for (int unsigned i = 1; i < SYNC_STG; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ss = sync_q[SYNC_STG-1];

  always_comb begin
    logic q1, q2, q3, q4, q5, q6;
    {q1, q2, q3, q4, q5, q6} = ss;
    cls = LEV_NONE;
    if (q1 && q2 && !q3 && !q4)                      cls = LEV_P;
    else if (q3 && q4 && !q1 && !q2)                 cls = LEV_N;
    else if (((q2 && q5) || (q3 && q6)) && !q1 && !q4) cls = LEV_O;
    sc = (q1 && q5) || (q4 && q6) || (q1 && q2 && q3 && (q4 || q6)) || (q2 && q3 && q4 && q5);
  end

  // Acceptance needs cls unchanged since last clk, so a fresh level never uses a stale count.
  assign acc = ce && (cls != LEV_NONE) && (cls == cls_q) && (stab_cnt >= t_filt);

  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q    <= LEV_NONE;
      stab_cnt <= '0;
    end else begin
      cls_q <= cls;
      if (cls != cls_q)                   stab_cnt <= '0;
      else if (ce && stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + STAB_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    lev_d     = v_lev_meas;
    valid_d   = lev_valid;
    dt_cnt_d  = dt_cnt;
    dt_last_d = dt_last;
    strobe_d  = 1'b0;
    fs_d      = fault_short;
    fd_d      = fault_dt;
    unique case (state_q)
      INIT: begin
        if (acc) begin
          lev_d   = cls;
          valid_d = 1'b1;
          state_d = STABLE;
        end
      end
      STABLE: begin
        if (cls != v_lev_meas) begin
          dt_cnt_d = '0;
          valid_d  = 1'b0;
          state_d  = TRANS;
        end
      end
      TRANS: begin
        if (acc) begin
          dt_last_d = dt_cnt;
          strobe_d  = 1'b1;
          lev_d     = cls;
          valid_d   = 1'b1;
          state_d   = STABLE;
        end else if (t_dt_max != '0 && dt_cnt >= t_dt_max) begin
          fd_d    = 1'b1;
          lev_d   = LEV_NONE;
          valid_d = 1'b0;
          state_d = FAULT;
        end else if (ce && dt_cnt != '1) begin
          dt_cnt_d = dt_cnt + 8'd1;
        end
      end
      FAULT: begin
        lev_d   = LEV_NONE;
        valid_d = 1'b0;
        if (fault_clr && !sc) begin
          fs_d    = 1'b0;
          fd_d    = 1'b0;
          state_d = INIT;
        end
      end
      default: state_d = INIT;
    endcase
    // Short overrides whatever the state logic decided this clk.
    if (sc) begin
      fs_d      = 1'b1;
      lev_d     = LEV_NONE;
      valid_d   = 1'b0;
      strobe_d  = 1'b0;
      dt_last_d = dt_last;
      state_d   = FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      v_lev_meas  <= LEV_NONE;
      lev_valid   <= 1'b0;
      dt_cnt      <= '0;
      dt_last     <= '0;
      dt_strobe   <= 1'b0;
      fault_short <= 1'b0;
      fault_dt    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_lev_meas  <= lev_d;
      lev_valid   <= valid_d;
      dt_cnt      <= dt_cnt_d;
      dt_last     <= dt_last_d;
      dt_strobe   <= strobe_d;
      fault_short <= fs_d;
      fault_dt    <= fd_d;
      fault       <= fs_d | fd_d;
    end
  end

endmodule

// File: tb/tb_monitor_3lanpc.sv
module tb_monitor_3lanpc;

  localparam logic [5:0]  PAT_P     = 6'b110001;
  localparam logic [5:0]  PAT_O     = 6'b011001;
  localparam logic [5:0]  PAT_N     = 6'b001110;
  localparam logic [5:0]  PAT_GAP   = 6'b010001;
  localparam logic [5:0]  PAT_OFF   = 6'b000000;
  localparam logic [5:0]  PAT_GL    = 6'b000001;
  localparam logic [5:0]  PAT_SHORT = 6'b110011;
  localparam logic [14:0] RST_OUTS  = {2'd3, 1'b0, 8'd0, 4'b0000};

  logic       clk, rst, ce, fault_clr;
  logic       s_1, s_2, s_3, s_4, s_5, s_6;
  logic [3:0] t_filt;
  logic [7:0] t_dt_max;
  logic [1:0] v_lev_meas;
  logic       lev_valid, dt_strobe, fault_short, fault_dt, fault;
  logic [7:0] dt_last;

  typedef struct {
    logic [7:0] dt;
    logic [1:0] lev;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  monitor_3lanpc #(.SYNC_STG(2), .FILT_W(4)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .s_1(s_1), .s_2(s_2), .s_3(s_3), .s_4(s_4), .s_5(s_5), .s_6(s_6),
    .t_filt(t_filt), .t_dt_max(t_dt_max), .fault_clr(fault_clr),
    .v_lev_meas(v_lev_meas), .lev_valid(lev_valid), .dt_last(dt_last), .dt_strobe(dt_strobe),
    .fault_short(fault_short), .fault_dt(fault_dt), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // Scoreboard: every dt_strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dt_strobe === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe dt_last=%0d v_lev_meas=%0d", dt_last, v_lev_meas);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dt_last !== e.dt || v_lev_meas !== e.lev || lev_valid !== 1'b1) begin
          bad++;
          $display("FAIL strobe_result got dt=%0d lev=%0d valid=%b want dt=%0d lev=%0d valid=1",
                   dt_last, v_lev_meas, lev_valid, e.dt, e.lev);
        end
      end
    end
  end

  function automatic logic [14:0] outs();
    return {v_lev_meas, lev_valid, dt_last, dt_strobe, fault_short, fault_dt, fault};
  endfunction

  task automatic drive(input logic [5:0] p);
    {s_1, s_2, s_3, s_4, s_5, s_6} = p;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int unsigned max_clk, output int unsigned n);
    n = 0;
    while (lev_valid !== 1'b1 && n < max_clk) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; fault_clr = 1'b0;
    t_filt = 4'd2; t_dt_max = 8'd0;
    drive(PAT_P);
    step(3);
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", outs(), RST_OUTS);
    end
  endtask

  task automatic test_first_accept();
    int unsigned n;
    rst = 1'b0;
    step(2);
    total++;
    if (lev_valid !== 1'b0) begin
      bad++;
      $display("FAIL accept_too_early lev_valid=%b want 0", lev_valid);
    end
    wait_valid(10, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2) begin
      bad++;
      $display("FAIL first_accept lev_valid=%b v_lev_meas=%0d want 1/2", lev_valid, v_lev_meas);
    end
  endtask

  task automatic test_commutation();
    int unsigned n;
    sb.push_back('{dt: 8'd7, lev: 2'd1});  // 5-clk gap + t_filt 2
    drive(PAT_GAP);
    step(3);
    total++;
    if (lev_valid !== 1'b0 || v_lev_meas !== 2'd2) begin
      bad++;
      $display("FAIL gap_hold lev_valid=%b v_lev_meas=%0d want 0/2", lev_valid, v_lev_meas);
    end
    step(2);
    drive(PAT_O);
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd1) begin
      bad++;
      $display("FAIL commutation_level lev_valid=%b v_lev_meas=%0d want 1/1", lev_valid, v_lev_meas);
    end
  endtask

  task automatic test_ce_gating();
    int unsigned n;
    ce = 1'b0;
    drive(PAT_N);
    step(12);
    total++;
    if (lev_valid !== 1'b0 || v_lev_meas !== 2'd1 || dt_strobe !== 1'b0) begin
      bad++;
      $display("FAIL ce_frozen lev_valid=%b v_lev_meas=%0d want 0/1", lev_valid, v_lev_meas);
    end
    sb.push_back('{dt: 8'd2, lev: 2'd0});  // dt counts only the t_filt ce ticks
    ce = 1'b1;
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd0) begin
      bad++;
      $display("FAIL ce_resume_level lev_valid=%b v_lev_meas=%0d want 1/0", lev_valid, v_lev_meas);
    end
  endtask

  task automatic test_dt_timeout();
    int unsigned n;
    t_dt_max = 8'd10;
    drive(PAT_OFF);
    step(13);
    total++;
    if (fault_dt !== 1'b0) begin
      bad++;
      $display("FAIL dt_timeout_early fault_dt=%b want 0", fault_dt);
    end
    step(1);
    total++;
    if ({fault_dt, fault, fault_short, lev_valid, v_lev_meas} !== 6'b110011) begin
      bad++;
      $display("FAIL dt_timeout got fdt=%b f=%b fs=%b valid=%b lev=%0d want 1/1/0/0/3",
               fault_dt, fault, fault_short, lev_valid, v_lev_meas);
    end
    step(6);
    total++;
    if (fault_dt !== 1'b1 || dt_last !== 8'd2) begin
      bad++;
      $display("FAIL dt_fault_hold fault_dt=%b dt_last=%0d want 1/2", fault_dt, dt_last);
    end
    t_dt_max = 8'd0;
    pulse_clr();
    total++;
    if (fault !== 1'b0 || fault_dt !== 1'b0) begin
      bad++;
      $display("FAIL dt_clear fault=%b fault_dt=%b want 0/0", fault, fault_dt);
    end
    drive(PAT_P);
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2) begin
      bad++;
      $display("FAIL reaccept_after_dt lev_valid=%b v_lev_meas=%0d want 1/2", lev_valid, v_lev_meas);
    end
  endtask

  task automatic test_short();
    int unsigned n;
    drive(PAT_SHORT);
    step(1);
    drive(PAT_P);
    step(1);
    total++;
    if (fault_short !== 1'b0) begin
      bad++;
      $display("FAIL short_early fault_short=%b want 0", fault_short);
    end
    step(1);
    total++;
    if ({fault_short, fault, lev_valid, v_lev_meas} !== 5'b11011) begin
      bad++;
      $display("FAIL short_latch got fs=%b f=%b valid=%b lev=%0d want 1/1/0/3",
               fault_short, fault, lev_valid, v_lev_meas);
    end
    drive(PAT_SHORT);
    step(3);
    pulse_clr();
    step(1);
    total++;
    if (fault_short !== 1'b1 || fault !== 1'b1) begin
      bad++;
      $display("FAIL clr_while_short fault_short=%b want 1", fault_short);
    end
    drive(PAT_P);
    step(3);
    pulse_clr();
    total++;
    if (fault_short !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL short_clear fault_short=%b fault=%b want 0/0", fault_short, fault);
    end
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2) begin
      bad++;
      $display("FAIL reaccept_after_short lev_valid=%b v_lev_meas=%0d want 1/2", lev_valid, v_lev_meas);
    end
  endtask

  task automatic test_glitch();
    int unsigned n;
    t_filt = 4'd4;
    sb.push_back('{dt: 8'd5, lev: 2'd2});  // 1-clk glitch + t_filt 4
    drive(PAT_GL);
    step(1);
    drive(PAT_P);
    step(3);
    wait_valid(20, n);
    step(2);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2 || fault !== 1'b0) begin
      bad++;
      $display("FAIL glitch_recover valid=%b lev=%0d fault=%b want 1/2/0", lev_valid, v_lev_meas, fault);
    end
    t_filt = 4'd2;
  endtask

  task automatic test_reset_mid();
    int unsigned n;
    drive(PAT_GAP);
    step(4);
    total++;
    if (lev_valid !== 1'b0) begin
      bad++;
      $display("FAIL trans_before_rst lev_valid=%b want 0", lev_valid);
    end
    rst = 1'b1;
    step(1);
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL rst_in_trans got=%b want=%b", outs(), RST_OUTS);
    end
    drive(PAT_P);
    step(1);
    rst = 1'b0;
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2) begin
      bad++;
      $display("FAIL accept_after_rst lev_valid=%b v_lev_meas=%0d want 1/2", lev_valid, v_lev_meas);
    end
    drive(PAT_SHORT);
    step(4);
    total++;
    if (fault_short !== 1'b1) begin
      bad++;
      $display("FAIL short_before_rst fault_short=%b want 1", fault_short);
    end
    rst = 1'b1;
    step(1);
    total++;
    if (outs() !== RST_OUTS) begin
      bad++;
      $display("FAIL rst_in_fault got=%b want=%b", outs(), RST_OUTS);
    end
    drive(PAT_P);
    step(1);
    rst = 1'b0;
    wait_valid(20, n);
    total++;
    if (lev_valid !== 1'b1 || v_lev_meas !== 2'd2 || fault !== 1'b0) begin
      bad++;
      $display("FAIL recover_after_rst valid=%b lev=%0d fault=%b want 1/2/0", lev_valid, v_lev_meas, fault);
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_commutation();
    test_ce_gating();
    test_dt_timeout();
    test_short();
    test_glitch();
    test_reset_mid();
    step(5);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_strobes pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
